// File: rtl/key_reader.sv
`default_nettype none
// ============================================================================
// Module      : key_reader
// Description : Synchronised, debounced key inputs exposed on the board bus
//               as a level register and a sticky press-event register.
// Revision    : 1.0 - initial release
// ============================================================================
module key_reader #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] key_i,
  input  logic             ce,
  input  logic             we,
  input  logic [1:0]       addr_i,
  input  logic [31:0]      data_i,
  output logic [31:0]      data_o,
  output logic             ack
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] c_id_word =
    {8'h4B, 8'h00, 8'(WIDTH), 8'(DEBOUNCE_CYCLES >= 256)};

  logic [WIDTH-1:0] w_key_level;
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_event;
  logic [WIDTH-1:0] w_press;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rdata;
  logic [31:0]      r_data;
  logic             r_ack;
  logic             w_accept;
  state_t           r_state;
  state_t           w_state_next;
  logic             w_unused_data;

  assign w_key_level   = ACTIVE_LOW ? ~key_i : key_i;
  assign w_unused_data = ^data_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_key_level;
      r_sync2 <= r_sync1;
    end
  end

  // The counter only advances while the synchronised level disagrees with the
  // accepted one, and is cleared on acceptance, so it can never pass c_cnt_max.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_key
      logic [CNT_W-1:0] r_cnt;
      logic             r_level;

      always_ff @(posedge clk) begin
        if (!rst) begin
          r_cnt   <= '0;
          r_level <= 1'b0;
        end else if (r_sync2[gi] == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == c_cnt_max) begin
          r_level <= r_sync2[gi];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign r_stable[gi] = r_level;
      assign w_press[gi]  = r_sync2[gi] & ~r_level & (r_cnt == c_cnt_max);
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ce) begin
          w_accept     = 1'b1;
          w_state_next = ST_ACK;
        end
      end
      ST_ACK: w_state_next = ST_IDLE;
    endcase
  end

  // A read of the event word clears exactly the bits it returns.
  always_comb begin
    w_rdata = '0;
    w_clr   = '0;
    case (addr_i)
      2'd0:    w_rdata[WIDTH-1:0] = r_stable;
      2'd1:    w_rdata[WIDTH-1:0] = r_event;
      2'd2:    w_rdata            = c_id_word;
      default: w_rdata            = '0;
    endcase
    if (w_accept && (addr_i == 2'd1)) begin
      w_clr = we ? data_i[WIDTH-1:0] : r_event;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
      r_data  <= '0;
      r_event <= '0;
    end else begin
      r_state <= w_state_next;
      r_ack   <= w_accept;
      r_data  <= (w_accept && !we) ? w_rdata : 32'd0;
      r_event <= (r_event & ~w_clr) | w_press;
    end
  end

  assign data_o = r_data;
  assign ack    = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_key_reader.sv
`default_nettype none
// Testbench for key_reader: scoreboard of expected read data, popped on ack.
module tb_key_reader;

  localparam int WIDTH = 4;
  localparam int DEBOUNCE_CYCLES = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] key_i;
  logic             ce;
  logic             we;
  logic [1:0]       addr_i;
  logic [31:0]      data_i;
  logic [31:0]      data_o;
  logic             ack;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  key_reader #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (16),
    .ACTIVE_LOW     (1'b1)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .key_i (key_i),
    .ce    (ce),
    .we    (we),
    .addr_i(addr_i),
    .data_i(data_i),
    .data_o(data_o),
    .ack   (ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One full access: accept edge, then ack edge. Writes expect data_o = 0.
  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input string tag);
    exp_t e;
    e.tag = tag;
    e.val = w ? 32'd0 : exp;
    sb.push_back(e);
    ce = 1'b1; we = w; addr_i = a; data_i = d;
    tick(1);
    ce = 1'b0; we = 1'b0; data_i = '0;
    tick(1);
    check({tag, "_ack_drop"}, {31'd0, ack}, 32'd0);
  endtask

  // Monitor: every ack pops one expectation; data_o must be 0 otherwise.
  always @(posedge clk) begin
    #1;
    if (ack) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(e.tag, data_o, e.val);
      end
    end else begin
      check("data_o_idle", data_o, 32'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; key_i = 4'b0000; ce = 1'b0; we = 1'b0; addr_i = 2'd0; data_i = '0;

    // Reset with all keys pressed
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_ack", {31'd0, ack}, 32'd0);
      check("rst_data", data_o, 32'd0);
    end
    rst = 1'b1;
    tick(5);
    bus(1'b0, 2'd0, '0, 32'h0, "stable_before_e6");
    bus(1'b0, 2'd0, '0, 32'hF, "stable_after_rst");
    bus(1'b0, 2'd1, '0, 32'hF, "event_after_rst");
    bus(1'b0, 2'd1, '0, 32'h0, "event_cleared");

    // Release everything; releases must not set events
    key_i = 4'hF;
    tick(8);
    bus(1'b0, 2'd0, '0, 32'h0, "stable_released");
    bus(1'b0, 2'd1, '0, 32'h0, "release_no_event");

    // Short glitch is rejected
    key_i = 4'hE;
    tick(3);
    key_i = 4'hF;
    tick(8);
    bus(1'b0, 2'd0, '0, 32'h0, "glitch_stable");
    bus(1'b0, 2'd1, '0, 32'h0, "glitch_event");

    // Held press accepted on the 6th edge
    key_i = 4'hE;
    tick(6);
    bus(1'b0, 2'd0, '0, 32'h1, "press_stable");
    bus(1'b0, 2'd1, '0, 32'h1, "press_event");
    tick(4);
    key_i = 4'hF;
    tick(8);

    // Read-clear
    key_i = 4'b1010;
    tick(8);
    key_i = 4'hF;
    tick(8);
    bus(1'b0, 2'd1, '0, 32'h5, "rdclr_first");
    bus(1'b0, 2'd1, '0, 32'h0, "rdclr_second");

    // W1C and set/clear collision
    key_i = 4'b1100;
    tick(8);
    key_i = 4'hF;
    tick(8);
    bus(1'b1, 2'd1, 32'h1, 32'h0, "w1c_write");
    key_i = 4'b1011;
    tick(5);
    bus(1'b1, 2'd1, 32'h4, 32'h0, "collision_write");
    bus(1'b0, 2'd1, '0, 32'h6, "collision_event");
    bus(1'b1, 2'd0, 32'hF, 32'h0, "ro_write");
    bus(1'b0, 2'd0, '0, 32'h4, "ro_stable");
    bus(1'b0, 2'd3, '0, 32'h0, "addr3_read");
    key_i = 4'hF;
    tick(8);

    // Back-to-back handshake with ce held high
    begin
      exp_t e;
      e.tag = "id_word";
      e.val = 32'h4B000400;
      sb.push_back(e);
      sb.push_back(e);
    end
    ce = 1'b1; we = 1'b0; addr_i = 2'd2;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("hs_ack", {31'd0, ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    ce = 1'b0;
    tick(1);

    // Reset coinciding with an accepted access
    key_i = 4'b1110;
    tick(8);
    key_i = 4'hF;
    tick(8);
    ce = 1'b1; we = 1'b0; addr_i = 2'd1; rst = 1'b0;
    tick(1);
    check("rst_mid_ack", {31'd0, ack}, 32'd0);
    ce = 1'b0; rst = 1'b1;
    tick(1);
    check("rst_mid_ack_after", {31'd0, ack}, 32'd0);
    bus(1'b0, 2'd1, '0, 32'h0, "rst_mid_event");

    tick(2);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
